// File: rtl/cpu_pkg.sv
// Shared CPU constants: NOP encoding, opcode/funct fields and the default reset vector.
package cpu_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  // Primary opcodes, instr[31:26]
  localparam logic [5:0] OP_ARITH = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type funct codes, instr[5:0]
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [1:0] {
    PC_HOLD     = 2'd0,
    PC_ADVANCE  = 2'd1,
    PC_REDIRECT = 2'd2
  } pc_sel_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter with +4 adder and reset > redirect > stall > advance next-PC selection.
module fetch_pc_reg
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus_four_o,
  output pc_sel_e     pc_sel_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] target_pc;
  pc_sel_e     pc_sel;

  // Targets are word aligned; the low two bits of the request are dropped.
  assign target_pc      = redirect_pc_i & ~32'h3;
  assign pc_plus_four_o = pc_q + PC_STEP;

  always_comb begin
    pc_sel = PC_ADVANCE;
    if (redirect_i) begin
      pc_sel = PC_REDIRECT;
    end else if (stall_i) begin
      pc_sel = PC_HOLD;
    end
  end

  always_comb begin
    pc_d = pc_q;
    unique case (pc_sel)
      PC_REDIRECT: pc_d = target_pc;
      PC_ADVANCE:  pc_d = pc_plus_four_o;
      default:     pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      pc_q <= RESET_PC & ~32'h3;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o     = pc_q;
  assign pc_sel_o = pc_sel;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage and IF/ID register. Define FETCH_STATS_EN to add the
// fetch_count / bubble_count statistics outputs.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus_four,
`ifdef FETCH_STATS_EN
  output logic        id_valid,
  output logic [31:0] fetch_count,
  output logic [31:0] bubble_count
`else
  output logic        id_valid
`endif
);

  logic [31:0] pc;
  logic [31:0] pc_plus_four;
  pc_sel_e     pc_sel;

  fetch_pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk           (clk),
    .rst_i         (reset),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .pc_o          (pc),
    .pc_plus_four_o(pc_plus_four),
    .pc_sel_o      (pc_sel)
  );

  assign imem_addr = pc;

  // IF -> ID boundary
  logic [31:0] instr_q, instr_d;
  logic [31:0] ppf_q, ppf_d;
  logic        valid_q, valid_d;

  always_comb begin
    instr_d = instr_q;
    ppf_d   = ppf_q;
    valid_d = valid_q;
    unique case (pc_sel)
      PC_REDIRECT: begin
        instr_d = NOP_INSTR;
        ppf_d   = 32'h0;
        valid_d = 1'b0;
      end
      PC_ADVANCE: begin
        instr_d = imem_data;
        ppf_d   = pc_plus_four;
        valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q <= NOP_INSTR;
      ppf_q   <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      ppf_q   <= ppf_d;
      valid_q <= valid_d;
    end
  end

  assign id_instr        = instr_q;
  assign id_pc_plus_four = ppf_q;
  assign id_valid        = valid_q;

`ifdef FETCH_STATS_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    fetch_cnt_d  = fetch_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (pc_sel == PC_ADVANCE) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
    if (pc_sel == PC_REDIRECT) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt_q  <= 32'h0;
      bubble_cnt_q <= 32'h0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign fetch_count  = fetch_cnt_q;
  assign bubble_count = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by random stall/redirect traffic
// compared against a cycle-level behavioural model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus_four;
  logic        id_valid;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count;
  logic [31:0] bubble_count;
`endif

  int n_chk = 0;
  int n_err = 0;

  // Reference state
  logic [31:0] m_pc, m_instr, m_ppf, m_fc, m_bc;
  logic        m_valid;

  always #5 clk = ~clk;

  // Memory word at byte address a is 0x1000_0000 + word index.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  always_comb imem_data = mem_word(imem_addr);

  fetch_stage #(.RESET_PC(32'h0)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .id_instr       (id_instr),
    .id_pc_plus_four(id_pc_plus_four),
`ifdef FETCH_STATS_EN
    .id_valid       (id_valid),
    .fetch_count    (fetch_count),
    .bubble_count   (bubble_count)
`else
    .id_valid       (id_valid)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".imem_addr"}, imem_addr, m_pc);
    chk({tag, ".id_instr"}, id_instr, m_instr);
    chk({tag, ".id_ppf"}, id_pc_plus_four, m_ppf);
    chk({tag, ".id_valid"}, {31'b0, id_valid}, {31'b0, m_valid});
`ifdef FETCH_STATS_EN
    chk({tag, ".fetch_count"}, fetch_count, m_fc);
    chk({tag, ".bubble_count"}, bubble_count, m_bc);
`endif
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_ppf = 32'h0; m_valid = 1'b0;
    m_fc = 32'h0; m_bc = 32'h0;
  endtask

  // One clock: drive inputs, take the edge, advance the model, sample 1ns later.
  task automatic step(input logic s, input logic r, input logic [31:0] rpc, input string tag);
    stall = s; redirect = r; redirect_pc = rpc;
    @(posedge clk);
    if (r) begin
      m_pc = {rpc[31:2], 2'b00};
      m_instr = 32'h0; m_ppf = 32'h0; m_valid = 1'b0; m_bc = m_bc + 1;
    end else if (!s) begin
      m_instr = mem_word(m_pc);
      m_ppf = m_pc + 4;
      m_valid = 1'b1;
      m_pc = m_pc + 4;
      m_fc = m_fc + 1;
    end
    #1;
    check_all(tag);
  endtask

  // Reset pulse placed strictly between clock edges.
  task automatic pulse_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;

    // Free run from reset vector
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, "free");
    chk("free_last_instr", id_instr, 32'h1000_0003);
    chk("free_last_ppf", id_pc_plus_four, 32'd16);

    pulse_reset("reset2");
    step(1'b0, 1'b0, 32'h0, "adv");
    step(1'b0, 1'b0, 32'h0, "adv");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, "stall");
    chk("stall_addr", imem_addr, 32'h8);
    chk("stall_instr", id_instr, 32'h1000_0001);
    step(1'b0, 1'b0, 32'h0, "release");
    chk("release_instr", id_instr, 32'h1000_0002);

    step(1'b0, 1'b1, 32'h40, "redir40");
    chk("redir40_pc", imem_addr, 32'h40);
    step(1'b0, 1'b0, 32'h0, "after40");
    chk("after40_ppf", id_pc_plus_four, 32'h44);

    step(1'b1, 1'b1, 32'h23, "redir_stall");
    chk("redir_stall_pc", imem_addr, 32'h20);
    step(1'b0, 1'b0, 32'h0, "after20");

    step(1'b0, 1'b1, 32'hFFFF_FFFC, "redir_top");
    step(1'b0, 1'b0, 32'h0, "wrap");
    chk("wrap_pc", imem_addr, 32'h0);
    chk("wrap_ppf", id_pc_plus_four, 32'h0);

    // Redirect to the current PC still costs one bubble
    step(1'b0, 1'b1, imem_addr, "redir_self");
    step(1'b0, 1'b1, 32'h100, "b2b_a");
    step(1'b0, 1'b1, 32'h200, "b2b_b");
    step(1'b0, 1'b0, 32'h0, "b2b_fetch");

    // Reset between edges while stalled
    stall = 1'b1;
    pulse_reset("reset_mid_stall");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, "cnt_adv");
    step(1'b1, 1'b0, 32'h0, "cnt_stall");
    step(1'b0, 1'b1, 32'h80, "cnt_redir");
    step(1'b0, 1'b1, 32'h90, "cnt_redir");
`ifdef FETCH_STATS_EN
    chk("fetch_count5", fetch_count, 32'd5);
    chk("bubble_count2", bubble_count, 32'd2);
`endif

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic s, r;
      logic [31:0] rpc;
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 6) == 0);
      case ($urandom_range(0, 3))
        0: rpc = imem_addr;
        1: rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: rpc = $urandom;
      endcase
      step(s, r, rpc, "rand");
      if ($urandom_range(0, 99) == 0) pulse_reset("rand_reset");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
